// File: rtl/vga_vram_pkg.sv
// Shared constants and FSM encoding for the VGA video-RAM arbiter.
package vga_vram_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int FB_DEPTH   = H_ACTIVE * V_ACTIVE;

    localparam int DEFAULT_AW = 19;
    localparam int DEFAULT_DW = 24;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vga_vram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   gidx,
    output logic            any
);

    // Scan from the farthest offset back toward ptr so the nearest requester wins.
    always_comb begin
        int idx;
        grant = '0;
        gidx  = '0;
        any   = |req;
        idx   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req[PW'(idx)]) begin
                gidx = PW'(idx);
            end
        end
        grant[gidx] = any;
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, writers share idle
// cycles round-robin with a one-cycle ack pulse per grant.
//
// state | meaning
// IDLE  | free to grant a writer in any cycle the display leaves the RAM idle
// ACK   | wr_ack pulse cycle; no write issued, display reads still served
module vga_vram_arbiter
    import vga_vram_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = FB_DEPTH,
    parameter int CNTW  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               disp_req,
    input  logic [AW-1:0]      disp_addr,
    output logic [DW-1:0]      disp_data,
    output logic               disp_rvalid,
    input  logic [NREQ-1:0]    wr_req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]    wr_ack,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic [CNTW-1:0]    wr_stall_cnt,
    output logic               addr_err
);

    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    arb_state_t      state, state_nxt;
    logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NREQ-1:0] ack_nxt;
    logic            stall_inc;
    logic            err_set;

    logic [NREQ-1:0] pick_grant;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    logic [AW-1:0]   req_addr [NREQ];
    logic [DW-1:0]   req_data [NREQ];
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic            win_in_range;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_addr[g] = wr_addr[g*AW +: AW];
        assign req_data[g] = wr_data[g*DW +: DW];
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (wr_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .gidx  (pick_idx),
        .any   (pick_any)
    );

    assign win_addr     = req_addr[pick_idx];
    assign win_data     = req_data[pick_idx];
    assign win_in_range = (32'(win_addr) < DEPTH_U);

    // RAM read data lands one cycle after the request, so gate it with the
    // registered request flag rather than registering it again.
    assign disp_data = disp_rvalid ? mem_rdata : '0;

    // Next-state decode plus the combinational RAM port mux.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        ack_nxt    = '0;
        stall_inc  = 1'b0;
        err_set    = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        if (disp_req) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end

        case (state)
            IDLE: begin
                if (pick_any) begin
                    if (disp_req) begin
                        stall_inc = 1'b1;
                    end else begin
                        ack_nxt    = pick_grant;
                        rr_ptr_nxt = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                        state_nxt  = ACK;
                        if (win_in_range) begin
                            mem_en    = 1'b1;
                            mem_we    = 1'b1;
                            mem_addr  = win_addr;
                            mem_wdata = win_data;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (reset) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer, ack, read-valid, stall counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            wr_ack       <= '0;
            disp_rvalid  <= 1'b0;
            wr_stall_cnt <= '0;
            addr_err     <= 1'b0;
        end else begin
            rr_ptr      <= rr_ptr_nxt;
            wr_ack      <= ack_nxt;
            disp_rvalid <= disp_req;
            if (stall_inc && (wr_stall_cnt != '1)) begin
                wr_stall_cnt <= wr_stall_cnt + 1'b1;
            end
            if (err_set) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: directed steps followed by random traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_vga_vram_arbiter;
    import vga_vram_pkg::*;

    localparam int NREQ  = 2;
    localparam int AW    = 19;
    localparam int DW    = 24;
    localparam int CNTW  = 16;
    localparam int DEPTH = FB_DEPTH;

    logic               clk = 1'b0;
    logic               reset;
    logic               disp_req;
    logic [AW-1:0]      disp_addr;
    logic [DW-1:0]      disp_data;
    logic               disp_rvalid;
    logic [NREQ-1:0]    wr_req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    wr_ack;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic [CNTW-1:0]    wr_stall_cnt;
    logic               addr_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_vram_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_data    (disp_data),
        .disp_rvalid  (disp_rvalid),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .wr_stall_cnt (wr_stall_cnt),
        .addr_err     (addr_err)
    );

    // Unwritten locations read back an address-derived pattern.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {5'b10101, a};
    endfunction

    // RAM environment: 256-word window, synchronous read, 1-cycle latency.
    logic [DW-1:0] ram_v [0:255];
    logic          ram_w [0:255];
    logic          mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) ram_w[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            ram_v[mem_addr[7:0]] <= mem_wdata;
            ram_w[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= ram_w[mem_addr[7:0]] ? ram_v[mem_addr[7:0]] : pat(mem_addr);
    end

    // Reference model state.
    bit              m_in_ack;
    int              m_ptr;
    int              m_stall;
    bit              m_err;
    logic [NREQ-1:0] m_ack;
    bit              m_rvalid;
    logic [AW-1:0]   m_raddr;
    logic [DW-1:0]   m_mem_v [0:255];
    bit              m_mem_w [0:255];

    function automatic logic [DW-1:0] m_lookup(input logic [AW-1:0] a);
        return m_mem_w[a[7:0]] ? m_mem_v[a[7:0]] : pat(a);
    endfunction

    task automatic model_reset();
        m_in_ack = 1'b0;
        m_ptr    = 0;
        m_stall  = 0;
        m_err    = 1'b0;
        m_ack    = '0;
        m_rvalid = 1'b0;
        m_raddr  = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
    endtask

    // One clock: predict, check at the falling edge, then advance the model.
    task automatic cycle();
        int            w;
        int            c;
        bit            rst, dreq;
        logic [AW-1:0] daddr, wa, xaddr;
        logic [DW-1:0] wd, xwd, xdd;
        logic          xen, xwe;

        rst = reset; dreq = disp_req; daddr = disp_addr;
        w = -1; wa = '0; wd = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (w < 0 && wr_req[c]) w = c;
        end
        if (w >= 0) begin
            wa = wr_addr[w*AW +: AW];
            wd = wr_data[w*DW +: DW];
        end

        xen = 1'b0; xwe = 1'b0; xaddr = '0; xwd = '0;
        if (!rst) begin
            if (dreq) begin
                xen = 1'b1; xaddr = daddr;
            end else if (!m_in_ack && w >= 0 && int'(wa) < DEPTH) begin
                xen = 1'b1; xwe = 1'b1; xaddr = wa; xwd = wd;
            end
        end
        xdd = m_rvalid ? m_lookup(m_raddr) : '0;

        @(negedge clk);
        chk("mem_en", 64'(mem_en), 64'(xen));
        chk("mem_we", 64'(mem_we), 64'(xwe));
        if (xen) chk("mem_addr", 64'(mem_addr), 64'(xaddr));
        if (xwe) chk("mem_wdata", 64'(mem_wdata), 64'(xwd));
        chk("wr_ack", 64'(wr_ack), 64'(m_ack));
        chk("disp_rvalid", 64'(disp_rvalid), 64'(m_rvalid));
        chk("disp_data", 64'(disp_data), 64'(xdd));
        chk("wr_stall_cnt", 64'(wr_stall_cnt), 64'(m_stall));
        chk("addr_err", 64'(addr_err), 64'(m_err));

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_rvalid = dreq;
            m_raddr  = daddr;
            m_ack    = '0;
            if (m_in_ack) begin
                m_in_ack = 1'b0;
            end else if (w >= 0) begin
                if (dreq) begin
                    if (m_stall < 65535) m_stall++;
                end else begin
                    m_ack[w] = 1'b1;
                    m_ptr    = (w + 1) % NREQ;
                    m_in_ack = 1'b1;
                    if (int'(wa) >= DEPTH) begin
                        m_err = 1'b1;
                    end else begin
                        m_mem_v[wa[7:0]] = wd;
                        m_mem_w[wa[7:0]] = 1'b1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic new_req(input int i);
        wr_req[i] = 1'b1;
        if ($urandom_range(0, 7) == 0)
            set_wr(i, AW'(DEPTH + int'($urandom_range(0, 1000))), DW'($urandom));
        else
            set_wr(i, AW'($urandom_range(0, 255)), DW'($urandom));
    endtask

    logic [NREQ-1:0] seen_acks [$];
    int              r;

    initial begin
        reset = 1'b1; mem_clear = 1'b1;
        disp_req = 1'b0; disp_addr = '0;
        wr_req = '0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 256; i++) m_mem_w[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        model_reset();

        // Reset state, then five idle cycles.
        cycle();
        reset = 1'b0;
        repeat (5) cycle();
        chk("idle_mem_en", 64'(mem_en), 64'(0));
        chk("idle_ack", 64'(wr_ack), 64'(0));

        // Display read at 0x10.
        disp_req = 1'b1; disp_addr = 19'h00010;
        cycle();
        disp_req = 1'b0;
        chk("rd_rvalid", 64'(disp_rvalid), 64'(1));
        chk("rd_data", 64'(disp_data), 64'(pat(19'h00010)));
        cycle();

        // Writer 0 writes 0xFF0000 at 100, then read it back.
        set_wr(0, 19'd100, 24'hFF0000);
        wr_req = 2'b01;
        cycle();
        chk("w0_ack", 64'(wr_ack), 64'(2'b01));
        wr_req = 2'b00;
        cycle();
        chk("w0_ack_drop", 64'(wr_ack), 64'(0));
        disp_req = 1'b1; disp_addr = 19'd100;
        cycle();
        disp_req = 1'b0;
        chk("w0_readback", 64'(disp_data), 64'(24'hFF0000));

        // Both writers held for 8 cycles after a fresh reset.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_wr(0, 19'd10, 24'h0000AA);
        set_wr(1, 19'd11, 24'h0000BB);
        wr_req = 2'b11;
        seen_acks.delete();
        for (int n = 0; n < 8; n++) begin
            cycle();
            if (wr_ack != '0) seen_acks.push_back(wr_ack);
        end
        chk("alt_count", 64'(seen_acks.size()), 64'(4));
        for (int k = 0; k < seen_acks.size() && k < 4; k++)
            chk("alt_order", 64'(seen_acks[k]), 64'((k % 2 == 0) ? 2'b01 : 2'b10));

        // Display busy for 10 cycles while writer 1 waits.
        set_wr(1, 19'd20, 24'h00CC00);
        wr_req = 2'b10;
        disp_req = 1'b1;
        for (int n = 0; n < 10; n++) begin
            disp_addr = AW'($urandom_range(0, 255));
            cycle();
        end
        chk("stall_cnt", 64'(wr_stall_cnt), 64'(10));
        chk("stall_no_ack", 64'(wr_ack), 64'(0));
        disp_req = 1'b0;
        cycle();
        chk("stall_then_ack", 64'(wr_ack), 64'(2'b10));
        wr_req = 2'b00;
        cycle();

        // Out-of-range write: acked, no RAM access, sticky error.
        set_wr(0, AW'(DEPTH), 24'h010203);
        wr_req = 2'b01;
        cycle();
        chk("oor_ack", 64'(wr_ack), 64'(2'b01));
        chk("oor_err", 64'(addr_err), 64'(1));
        wr_req = 2'b00;
        cycle();

        // Reset right after a grant: write sticks, ack and error clear.
        set_wr(0, 19'd50, 24'h123456);
        wr_req = 2'b01;
        cycle();
        reset = 1'b1;
        cycle();
        chk("rst_ack", 64'(wr_ack), 64'(0));
        chk("rst_err", 64'(addr_err), 64'(0));
        chk("rst_stall", 64'(wr_stall_cnt), 64'(0));
        reset = 1'b0;
        cycle();
        chk("rereq_ack", 64'(wr_ack), 64'(2'b01));
        wr_req = 2'b00;
        cycle();
        disp_req = 1'b1; disp_addr = 19'd50;
        cycle();
        disp_req = 1'b0;
        chk("rst_write_kept", 64'(disp_data), 64'(24'h123456));

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 149) == 0);
            disp_req  = ($urandom_range(0, 9) < 4);
            disp_addr = AW'($urandom_range(0, 255));
            for (int i = 0; i < NREQ; i++) begin
                if (m_ack[i] || !wr_req[i]) begin
                    r = int'($urandom_range(0, 2));
                    if (r == 0 || (m_ack[i] && r == 1)) new_req(i);
                    else wr_req[i] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    wr_req[i] = 1'b0;
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
